// File: rtl/xbus_pkg.sv
// Shared types and constants for the X-bus multicaster.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: bus mode encoding, drop counter width, column index width helper.
package xbus_pkg;

   typedef enum logic [1:0] {
      XB_UNICAST = 2'b00,
      XB_BCAST   = 2'b01,
      XB_MASK    = 2'b10,
      XB_RSVD    = 2'b11
   } xb_mode_e;

   localparam int DROP_CNT_W = 16;

   // A single column still needs a 1-bit index field on the bus.
   function automatic int col_w(input int num_col);
      return (num_col > 1) ? $clog2(num_col) : 1;
   endfunction

endpackage

// File: rtl/x_bus_multicaster_if.sv
// Bus-side and PE-side handshake bundle of the X-bus multicaster.
// Latency: n/a (wires only).
// Backpressure: bus_ready from the caster, pe_ready per column from the PEs.
// master: bus driver + PE row (drives bus_*, pe_ready); slave: the caster.
interface x_bus_multicaster_if
   import xbus_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_COL    = 4
);
   localparam int COL_W = col_w(NUM_COL);

   logic                          bus_valid;
   logic                          bus_ready;
   logic [DATA_WIDTH-1:0]         bus_data;
   logic [1:0]                    bus_mode;
   logic [COL_W-1:0]              bus_col;
   logic [NUM_COL-1:0]            bus_mask;
   logic [NUM_COL-1:0]            pe_valid;
   logic [NUM_COL-1:0]            pe_ready;
   logic [NUM_COL*DATA_WIDTH-1:0] pe_data;

   modport master (
      output bus_valid, bus_data, bus_mode, bus_col, bus_mask, pe_ready,
      input  bus_ready, pe_valid, pe_data
   );

   modport slave (
      input  bus_valid, bus_data, bus_mode, bus_col, bus_mask, pe_ready,
      output bus_ready, pe_valid, pe_data
   );

endinterface

// File: rtl/xbus_col_fifo.sv
// Per-column word FIFO feeding one PE column.
// Latency: a word pushed at edge N is visible on pop_data after edge N.
// Backpressure: push ignored when full, pop ignored when empty; full uses the registered count only.
// Ports: clk, rst, push/push_data, pop, pop_data, full, empty, count.
module xbus_col_fifo #(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic [DATA_WIDTH-1:0]         push_data,
   input  logic                          pop,
   output logic [DATA_WIDTH-1:0]         pop_data,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_V = CNT_W'(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [DATA_WIDTH-1:0] last_pop;
   logic                  do_push;
   logic                  do_pop;

   assign full    = (count == DEPTH_V);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // An empty column keeps showing the last word it handed out.
   assign pop_data = empty ? last_pop : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Depth is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         last_pop <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr   <= rd_ptr + 1'b1;
            last_pop <= mem[rd_ptr];
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/x_bus_multicaster.sv
// Delivers each X-bus word to one, several or all PE columns (unicast/broadcast/mask).
// Latency: one cycle from bus handshake to pe_valid on every targeted column.
// Backpressure: bus_ready drops when any targeted column FIFO is full; untargetable words are always taken and dropped.
// Ports: clk, rst, caster_en, xb (bus + PE handshakes), col_busy, drop_cnt, err.
module x_bus_multicaster
   import xbus_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_COL    = 4,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  caster_en,
   x_bus_multicaster_if.slave    xb,
   output logic [NUM_COL-1:0]    col_busy,
   output logic [DROP_CNT_W-1:0] drop_cnt,
   output logic                  err
);
   localparam int COL_W = col_w(NUM_COL);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [NUM_COL-1:0] tgt;
   logic [NUM_COL-1:0] col_full;
   logic [NUM_COL-1:0] col_empty;
   logic [NUM_COL-1:0] push;
   logic [NUM_COL-1:0] pop;
   logic [CNT_W-1:0]   col_count [NUM_COL];
   logic               accept;
   logic               drop;

   // Target decode. An out-of-range unicast index matches no column, so it
   // falls out as an empty target set just like mask==0 and reserved mode.
   always_comb begin
      tgt = '0;
      case (xb.bus_mode)
         XB_UNICAST: begin
            for (int c = 0; c < NUM_COL; c++) begin
               tgt[c] = (xb.bus_col == COL_W'(c));
            end
         end
         XB_BCAST: tgt = '1;
         XB_MASK:  tgt = xb.bus_mask;
         default:  tgt = '0;
      endcase
   end

   // All-or-nothing delivery: accept only when every targeted column has room.
   assign xb.bus_ready = caster_en & ~|(tgt & col_full);
   assign accept       = xb.bus_valid & xb.bus_ready;
   assign push         = {NUM_COL{accept}} & tgt;
   assign drop         = accept & (tgt == '0);
   assign pop          = xb.pe_valid & xb.pe_ready;

   for (genvar c = 0; c < NUM_COL; c++) begin : g_col
      xbus_col_fifo #(
         .DATA_WIDTH (DATA_WIDTH),
         .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk       (clk),
         .rst       (rst),
         .push      (push[c]),
         .push_data (xb.bus_data),
         .pop       (pop[c]),
         .pop_data  (xb.pe_data[c*DATA_WIDTH +: DATA_WIDTH]),
         .full      (col_full[c]),
         .empty     (col_empty[c]),
         .count     (col_count[c])
      );

      assign xb.pe_valid[c] = ~col_empty[c];
      assign col_busy[c]    = |col_count[c];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt <= '0;
         err      <= 1'b0;
      end else if (drop) begin
         err <= 1'b1;
         if (drop_cnt != {DROP_CNT_W{1'b1}}) begin
            drop_cnt <= drop_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_x_bus_multicaster.sv
// Testbench for x_bus_multicaster: 4-column main instance with a queue scoreboard,
// plus a 3-column instance for out-of-range unicast drops.
module tb_x_bus_multicaster;
   import xbus_pkg::*;

   localparam int DW    = 16;
   localparam int NC    = 4;
   localparam int NC3   = 3;
   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic rst;
   logic caster_en;
   logic caster_en3;
   logic [NC-1:0]  col_busy;
   logic [15:0]    drop_cnt;
   logic           err;
   logic [NC3-1:0] col_busy3;
   logic [15:0]    drop_cnt3;
   logic           err3;

   always #5 clk = ~clk;

   x_bus_multicaster_if #(.DATA_WIDTH(DW), .NUM_COL(NC))  xb  ();
   x_bus_multicaster_if #(.DATA_WIDTH(DW), .NUM_COL(NC3)) xb3 ();

   x_bus_multicaster #(.DATA_WIDTH(DW), .NUM_COL(NC), .FIFO_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .caster_en (caster_en),
      .xb        (xb.slave),
      .col_busy  (col_busy),
      .drop_cnt  (drop_cnt),
      .err       (err)
   );

   x_bus_multicaster #(.DATA_WIDTH(DW), .NUM_COL(NC3), .FIFO_DEPTH(DEPTH)) dut3 (
      .clk       (clk),
      .rst       (rst),
      .caster_en (caster_en3),
      .xb        (xb3.slave),
      .col_busy  (col_busy3),
      .drop_cnt  (drop_cnt3),
      .err       (err3)
   );

   // Scoreboard state for the 4-column instance.
   logic [DW-1:0] exp_q [NC][$];
   int            pop_cnt [NC];
   logic [15:0]   exp_drop;
   logic          exp_err;
   int            n_cmp = 0;
   int            n_bad = 0;

   function automatic logic [NC-1:0] model_tgt(input logic [1:0] mode, input logic [1:0] col,
                                               input logic [NC-1:0] mask);
      logic [NC-1:0] one;
      one = 4'b0001;
      case (mode)
         2'b00:   return one << col;
         2'b01:   return 4'b1111;
         2'b10:   return mask;
         default: return 4'b0000;
      endcase
   endfunction

   task automatic model_clear();
      for (int c = 0; c < NC; c++) begin
         exp_q[c].delete();
         pop_cnt[c] = 0;
      end
      exp_drop = '0;
      exp_err  = 1'b0;
   endtask

   // One clock: at the negedge compare outputs, retire expected words the PEs
   // consume, queue expected words for the handshake about to happen; return
   // 1 time unit after the following posedge.
   task automatic tick();
      logic [NC-1:0] t;
      logic          exp_rdy;
      logic [DW-1:0] w;
      @(negedge clk);
      if (!rst) begin
         t       = model_tgt(xb.bus_mode, xb.bus_col, xb.bus_mask);
         exp_rdy = caster_en;
         for (int c = 0; c < NC; c++) begin
            if (t[c] && exp_q[c].size() >= DEPTH) exp_rdy = 1'b0;
         end
         if (xb.bus_valid) begin
            n_cmp++;
            if (xb.bus_ready !== exp_rdy) begin
               n_bad++;
               $display("FAIL sb_bus_ready t=%0t: got %b want %b", $time, xb.bus_ready, exp_rdy);
            end
         end
         for (int c = 0; c < NC; c++) begin
            n_cmp++;
            if (xb.pe_valid[c] !== (exp_q[c].size() != 0)) begin
               n_bad++;
               $display("FAIL sb_pe_valid[%0d] t=%0t: got %b want %b", c, $time,
                        xb.pe_valid[c], exp_q[c].size() != 0);
            end
            n_cmp++;
            if (col_busy[c] !== (exp_q[c].size() != 0)) begin
               n_bad++;
               $display("FAIL sb_col_busy[%0d] t=%0t: got %b want %b", c, $time,
                        col_busy[c], exp_q[c].size() != 0);
            end
            if (exp_q[c].size() != 0 && xb.pe_ready[c]) begin
               w = exp_q[c].pop_front();
               pop_cnt[c]++;
               n_cmp++;
               if (xb.pe_data[c*DW +: DW] !== w) begin
                  n_bad++;
                  $display("FAIL sb_pe_data[%0d] t=%0t: got %h want %h", c, $time,
                           xb.pe_data[c*DW +: DW], w);
               end
            end
         end
         n_cmp++;
         if (drop_cnt !== exp_drop || err !== exp_err) begin
            n_bad++;
            $display("FAIL sb_drop t=%0t: got cnt=%0d err=%b want cnt=%0d err=%b", $time,
                     drop_cnt, err, exp_drop, exp_err);
         end
         if (xb.bus_valid && exp_rdy) begin
            if (t == '0) begin
               exp_err = 1'b1;
               if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
            end else begin
               for (int c = 0; c < NC; c++) begin
                  if (t[c]) exp_q[c].push_back(xb.bus_data);
               end
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_cmp++;
      if (xb.pe_valid !== 4'b0 || col_busy !== 4'b0 || xb.pe_data !== 64'b0) begin
         n_bad++;
         $display("FAIL reset_outputs: got pe_valid=%b busy=%b data=%h want 0/0/0",
                  xb.pe_valid, col_busy, xb.pe_data);
      end
      n_cmp++;
      if (drop_cnt !== 16'd0 || err !== 1'b0 || drop_cnt3 !== 16'd0 || err3 !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_drop: got %0d/%b %0d/%b want 0/0", drop_cnt, err, drop_cnt3, err3);
      end
      n_cmp++;
      if (xb3.pe_valid !== 3'b0 || col_busy3 !== 3'b0) begin
         n_bad++;
         $display("FAIL reset_dut3: got pe_valid=%b busy=%b want 0", xb3.pe_valid, col_busy3);
      end
      model_clear();
      rst = 1'b0;
   endtask

   task automatic test_unicast();
      caster_en = 1'b1;
      xb.pe_ready = 4'hF;
      xb.bus_valid = 1'b1; xb.bus_mode = 2'b00; xb.bus_col = 2'd2; xb.bus_data = 16'h1234;
      #1;
      n_cmp++;
      if (xb.bus_ready !== 1'b1) begin
         n_bad++; $display("FAIL unicast_ready: got %b want 1", xb.bus_ready);
      end
      tick();
      xb.bus_valid = 1'b0;
      n_cmp++;
      if (xb.pe_valid !== 4'b0100 || xb.pe_data[2*DW +: DW] !== 16'h1234) begin
         n_bad++;
         $display("FAIL unicast_deliver: got %b/%h want 0100/1234", xb.pe_valid, xb.pe_data[2*DW +: DW]);
      end
      tick();
      n_cmp++;
      if (xb.pe_valid !== 4'b0) begin
         n_bad++; $display("FAIL unicast_drain: got %b want 0000", xb.pe_valid);
      end
   endtask

   task automatic test_broadcast();
      for (int c = 0; c < NC; c++) pop_cnt[c] = 0;
      xb.pe_ready = 4'b1101;
      xb.bus_valid = 1'b1; xb.bus_mode = 2'b01; xb.bus_data = 16'hA5A5;
      tick();
      tick();
      n_cmp++;
      if (xb.bus_ready !== 1'b0) begin
         n_bad++; $display("FAIL bcast_blocked: got %b want 0", xb.bus_ready);
      end
      tick();
      tick();
      xb.pe_ready = 4'hF;
      #1;
      n_cmp++;
      if (xb.bus_ready !== 1'b0) begin
         n_bad++; $display("FAIL bcast_no_passthru: got %b want 0", xb.bus_ready);
      end
      tick();
      n_cmp++;
      if (xb.bus_ready !== 1'b1) begin
         n_bad++; $display("FAIL bcast_resume: got %b want 1", xb.bus_ready);
      end
      tick();
      xb.bus_valid = 1'b0;
      repeat (3) tick();
      for (int c = 0; c < NC; c++) begin
         n_cmp++;
         if (pop_cnt[c] != 3) begin
            n_bad++; $display("FAIL bcast_count[%0d]: got %0d want 3", c, pop_cnt[c]);
         end
      end
   endtask

   task automatic test_mask();
      xb.pe_ready = 4'b0;
      xb.bus_valid = 1'b1; xb.bus_mode = 2'b10; xb.bus_mask = 4'b1010; xb.bus_data = 16'h0F0F;
      tick();
      xb.bus_valid = 1'b0;
      n_cmp++;
      if (xb.pe_valid !== 4'b1010 || col_busy !== 4'b1010) begin
         n_bad++; $display("FAIL mask_deliver: got %b/%b want 1010/1010", xb.pe_valid, col_busy);
      end
      n_cmp++;
      if (xb.pe_data[1*DW +: DW] !== 16'h0F0F || xb.pe_data[3*DW +: DW] !== 16'h0F0F) begin
         n_bad++;
         $display("FAIL mask_data: got %h/%h want 0f0f", xb.pe_data[1*DW +: DW], xb.pe_data[3*DW +: DW]);
      end
      repeat (2) tick();
      n_cmp++;
      if (col_busy !== 4'b1010) begin
         n_bad++; $display("FAIL mask_hold: got %b want 1010", col_busy);
      end
      xb.pe_ready = 4'hF;
      tick();
      n_cmp++;
      if (col_busy !== 4'b0 || xb.pe_valid !== 4'b0) begin
         n_bad++; $display("FAIL mask_drain: got %b/%b want 0000", col_busy, xb.pe_valid);
      end
   endtask

   task automatic test_drop();
      xb.pe_ready = 4'hF;
      xb.bus_valid = 1'b1; xb.bus_mode = 2'b11; xb.bus_col = 2'd0; xb.bus_data = 16'hDEAD;
      #1;
      n_cmp++;
      if (xb.bus_ready !== 1'b1) begin
         n_bad++; $display("FAIL drop_ready: got %b want 1", xb.bus_ready);
      end
      tick();
      xb.bus_mode = 2'b10; xb.bus_mask = 4'b0;
      tick();
      xb.bus_valid = 1'b0;
      n_cmp++;
      if (drop_cnt !== 16'd2 || err !== 1'b1 || xb.pe_valid !== 4'b0) begin
         n_bad++;
         $display("FAIL drop_count: got %0d/%b/%b want 2/1/0000", drop_cnt, err, xb.pe_valid);
      end
   endtask

   task automatic test_drop_3col();
      caster_en3 = 1'b1;
      xb3.pe_ready = 3'b111;
      xb3.bus_valid = 1'b1; xb3.bus_mode = 2'b00; xb3.bus_col = 2'd3; xb3.bus_data = 16'h7777;
      #1;
      n_cmp++;
      if (xb3.bus_ready !== 1'b1) begin
         n_bad++; $display("FAIL col3_ready: got %b want 1", xb3.bus_ready);
      end
      tick();
      n_cmp++;
      if (xb3.pe_valid !== 3'b0 || drop_cnt3 !== 16'd1 || err3 !== 1'b1) begin
         n_bad++;
         $display("FAIL col3_drop: got %b/%0d/%b want 000/1/1", xb3.pe_valid, drop_cnt3, err3);
      end
      xb3.bus_mode = 2'b10; xb3.bus_mask = 3'b0;
      tick();
      n_cmp++;
      if (drop_cnt3 !== 16'd2) begin
         n_bad++; $display("FAIL col3_mask0: got %0d want 2", drop_cnt3);
      end
      xb3.bus_mode = 2'b00; xb3.bus_col = 2'd2; xb3.bus_data = 16'h3333;
      tick();
      xb3.bus_valid = 1'b0;
      n_cmp++;
      if (xb3.pe_valid !== 3'b100 || xb3.pe_data[2*DW +: DW] !== 16'h3333) begin
         n_bad++;
         $display("FAIL col3_unicast: got %b/%h want 100/3333", xb3.pe_valid, xb3.pe_data[2*DW +: DW]);
      end
      tick();
      n_cmp++;
      if (xb3.pe_valid !== 3'b0 || drop_cnt3 !== 16'd2) begin
         n_bad++; $display("FAIL col3_final: got %b/%0d want 000/2", xb3.pe_valid, drop_cnt3);
      end
   endtask

   task automatic test_disable();
      caster_en = 1'b1;
      xb.pe_ready = 4'b0;
      xb.bus_valid = 1'b1; xb.bus_mode = 2'b00; xb.bus_col = 2'd0; xb.bus_data = 16'h1111;
      tick();
      xb.bus_data = 16'h2222;
      tick();
      caster_en = 1'b0;
      xb.bus_mode = 2'b01; xb.bus_data = 16'h9999;
      xb.pe_ready = 4'hF;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_cmp++;
         if (xb.bus_ready !== 1'b0) begin
            n_bad++; $display("FAIL disable_ready cycle %0d: got %b want 0", i, xb.bus_ready);
         end
         tick();
      end
      n_cmp++;
      if (xb.pe_valid !== 4'b0 || col_busy !== 4'b0) begin
         n_bad++; $display("FAIL disable_drain: got %b/%b want 0000", xb.pe_valid, col_busy);
      end
      xb.bus_valid = 1'b0;
      caster_en = 1'b1;
   endtask

   task automatic test_async_reset();
      xb.pe_ready = 4'b0;
      xb.bus_valid = 1'b1; xb.bus_mode = 2'b00; xb.bus_col = 2'd0; xb.bus_data = 16'hAAAA;
      tick();
      xb.bus_data = 16'hBBBB;
      tick();
      xb.bus_valid = 1'b0;
      n_cmp++;
      if (xb.pe_valid !== 4'b0001 || col_busy !== 4'b0001) begin
         n_bad++; $display("FAIL areset_preload: got %b/%b want 0001", xb.pe_valid, col_busy);
      end
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (xb.pe_valid !== 4'b0 || col_busy !== 4'b0 || xb.pe_data !== 64'b0) begin
         n_bad++;
         $display("FAIL areset_outputs: got %b/%b/%h want 0", xb.pe_valid, col_busy, xb.pe_data);
      end
      n_cmp++;
      if (drop_cnt !== 16'd0 || err !== 1'b0) begin
         n_bad++; $display("FAIL areset_drop: got %0d/%b want 0/0", drop_cnt, err);
      end
      model_clear();
      tick();
      rst = 1'b0;
      xb.pe_ready = 4'hF;
      xb.bus_valid = 1'b1; xb.bus_mode = 2'b00; xb.bus_col = 2'd3; xb.bus_data = 16'hC0DE;
      tick();
      xb.bus_valid = 1'b0;
      n_cmp++;
      if (xb.pe_valid !== 4'b1000 || xb.pe_data[3*DW +: DW] !== 16'hC0DE) begin
         n_bad++;
         $display("FAIL areset_after: got %b/%h want 1000/c0de", xb.pe_valid, xb.pe_data[3*DW +: DW]);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 80; i++) begin
         xb.bus_valid = ($urandom_range(0, 3) != 0);
         xb.bus_mode  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         xb.bus_col   = 2'($urandom_range(0, 3));
         xb.bus_mask  = 4'($urandom_range(0, 15));
         xb.bus_data  = 16'($urandom);
         xb.pe_ready  = 4'($urandom_range(0, 15));
         caster_en    = ($urandom_range(0, 7) != 0);
         tick();
      end
      xb.bus_valid = 1'b0;
      caster_en = 1'b1;
      xb.pe_ready = 4'hF;
      repeat (4) tick();
      n_cmp++;
      if (xb.pe_valid !== 4'b0 || drop_cnt !== exp_drop) begin
         n_bad++;
         $display("FAIL b2b_final: got %b/%0d want 0000/%0d", xb.pe_valid, drop_cnt, exp_drop);
      end
   endtask

   initial begin
      rst = 1'b1;
      caster_en = 1'b0;
      caster_en3 = 1'b0;
      xb.bus_valid = 1'b0; xb.bus_data = '0; xb.bus_mode = 2'b00; xb.bus_col = '0;
      xb.bus_mask = '0; xb.pe_ready = '0;
      xb3.bus_valid = 1'b0; xb3.bus_data = '0; xb3.bus_mode = 2'b00; xb3.bus_col = '0;
      xb3.bus_mask = '0; xb3.pe_ready = '0;
      model_clear();

      test_reset();
      test_unicast();
      test_broadcast();
      test_mask();
      test_drop();
      test_drop_3col();
      test_disable();
      test_async_reset();
      test_back_to_back();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
